// File: rtl/w4823_fir_cload_seq_if.sv
// Coefficient stream (s_*) and CMEM write port (cload/caddr/cin) of the FIR
// coefficient-load sequencer, bundled as one interface.
interface w4823_fir_cload_seq_if #(
    parameter int unsigned CAW = 6
);
    logic           s_valid;
    logic           s_ready;
    logic [15:0]    s_data;
    logic           cload;
    logic [CAW-1:0] caddr;
    logic [15:0]    cin;

    // Upstream producer / FIR side
    modport master (
        output s_valid, s_data,
        input  s_ready, cload, caddr, cin
    );

    // Sequencer side
    modport slave (
        input  s_valid, s_data,
        output s_ready, cload, caddr, cin
    );
endinterface

// File: rtl/w4823_fir_cload_seq.sv
// Coefficient-load sequencer for W4823_FIR: takes FP16 words off a valid/ready
// stream, flushes denormals to signed zero, aborts on Inf/NaN and writes the
// words to CMEM at addresses 0..NTAPS-1 through the FIR cload/caddr/cin port.
module w4823_fir_cload_seq #(
    parameter int unsigned NTAPS = 64,
    parameter int unsigned CAW   = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    w4823_fir_cload_seq_if.slave   bus,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [CAW:0]           denorm_cnt
);
    localparam logic [CAW-1:0] IDX_LAST = CAW'(NTAPS - 1);
    localparam logic [CAW:0]   CNT_MAX  = (CAW + 1)'(NTAPS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t         state;
    logic [CAW-1:0] idx;

    logic           w_sign;
    logic [4:0]     w_exp;
    logic [9:0]     w_mant;
    logic           w_special;
    logic           w_denorm;
    logic           accept;

    // Field decode of the offered word; s_ready is a flop that mirrors state==LOAD
    assign w_sign    = bus.s_data[15];
    assign w_exp     = bus.s_data[14:10];
    assign w_mant    = bus.s_data[9:0];
    assign w_special = (w_exp == 5'h1F);
    assign w_denorm  = (w_exp == 5'h00) && (w_mant != 10'h000);
    assign accept    = bus.s_valid && bus.s_ready;

    // Sequencer FSM with all outputs registered; s_ready/busy track the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            bus.s_ready <= 1'b0;
            bus.cload   <= 1'b0;
            bus.caddr   <= '0;
            bus.cin     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            denorm_cnt  <= '0;
        end else begin
            bus.cload <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state       <= LOAD;
                        idx         <= '0;
                        denorm_cnt  <= '0;
                        done        <= 1'b0;
                        err         <= 1'b0;
                        bus.s_ready <= 1'b1;
                        busy        <= 1'b1;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        if (w_special) begin
                            // Inf/NaN aborts the sequence without a write
                            state       <= ERR;
                            err         <= 1'b1;
                            bus.s_ready <= 1'b0;
                            busy        <= 1'b0;
                        end else begin
                            bus.cload <= 1'b1;
                            bus.caddr <= idx;
                            bus.cin   <= w_denorm ? {w_sign, 15'b0} : bus.s_data;
                            if (w_denorm && (denorm_cnt != CNT_MAX)) begin
                                denorm_cnt <= denorm_cnt + (CAW + 1)'(1);
                            end
                            if (idx == IDX_LAST) begin
                                state       <= DONE;
                                done        <= 1'b1;
                                bus.s_ready <= 1'b0;
                                busy        <= 1'b0;
                            end else begin
                                idx <= idx + CAW'(1);
                            end
                        end
                    end
                end
                default: begin
                    state       <= IDLE;
                    bus.s_ready <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_w4823_fir_cload_seq.sv
// Scoreboard bench for w4823_fir_cload_seq: the driver pushes the expected
// CMEM write for every accepted word, a negedge monitor pops on each cload.
module tb_w4823_fir_cload_seq;
    localparam int unsigned NTAPS = 64;
    localparam int unsigned CAW   = 6;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           busy;
    logic           done;
    logic           err;
    logic [CAW:0]   denorm_cnt;

    w4823_fir_cload_seq_if #(.CAW(CAW)) bus ();

    w4823_fir_cload_seq #(.NTAPS(NTAPS), .CAW(CAW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .denorm_cnt (denorm_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CAW-1:0] addr;
        logic [15:0]    data;
        logic           last;
    } wr_t;

    wr_t sb[$];
    int  n_pass  = 0;
    int  n_total = 0;
    int  n_cload = 0;
    int  exp_addr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: every cload must match the oldest expected write
    always @(negedge clk) begin
        wr_t e;
        if (bus.cload === 1'b1) begin
            n_cload++;
            if (sb.size() == 0) begin
                chk("unexpected_cload", 32'(bus.caddr), 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk("caddr", 32'(bus.caddr), 32'(e.addr));
                chk("cin", 32'(bus.cin), 32'(e.data));
                chk("done_with_cload", 32'(done), 32'(e.last));
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        exp_addr = 0;
    endtask

    // Offer one word; ecin is the hand-computed CMEM data, bad marks Inf/NaN
    task automatic send_word(input logic [15:0] d, input logic [15:0] ecin,
                             input bit bad, input bit st);
        int waited;
        waited = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        start       = st;
        while (bus.s_ready !== 1'b1 && waited < 20) begin
            tick(1);
            waited++;
        end
        if (bus.s_ready !== 1'b1) begin
            chk("accept_timeout", 32'(bus.s_ready), 32'd1);
        end else begin
            if (!bad) begin
                sb.push_back('{addr: CAW'(exp_addr), data: ecin,
                               last: 1'(exp_addr == NTAPS - 1)});
                exp_addr++;
            end
            tick(1);
        end
        bus.s_valid = 1'b0;
        start       = 1'b0;
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while (sb.size() != 0 && waited < 5) begin
            tick(1);
            waited++;
        end
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    endtask

    task automatic send_normals(input int first, input int last_excl);
        for (int i = first; i < last_excl; i++) begin
            send_word(16'h3C00 + 16'(i), 16'h3C00 + 16'(i), 1'b0, 1'b0);
        end
    endtask

    initial begin
        logic [15:0] d;
        logic [15:0] e;
        rst         = 1'b1;
        start       = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        do_reset();

        // Reset state
        chk("rst_s_ready", 32'(bus.s_ready), 32'd0);
        chk("rst_cload", 32'(bus.cload), 32'd0);
        chk("rst_caddr", 32'(bus.caddr), 32'd0);
        chk("rst_cin", 32'(bus.cin), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_denorm", 32'(denorm_cnt), 32'd0);

        // Full back-to-back load
        do_start();
        chk("load_s_ready", 32'(bus.s_ready), 32'd1);
        chk("load_busy", 32'(busy), 32'd1);
        send_normals(0, 64);
        drain();
        chk("full_done", 32'(done), 32'd1);
        chk("full_busy", 32'(busy), 32'd0);
        chk("full_s_ready", 32'(bus.s_ready), 32'd0);
        chk("full_denorm", 32'(denorm_cnt), 32'd0);
        chk("full_err", 32'(err), 32'd0);

        // s_valid in DONE is ignored
        bus.s_valid = 1'b1;
        bus.s_data  = 16'h4000;
        tick(3);
        bus.s_valid = 1'b0;
        chk("done_hold", 32'(done), 32'd1);
        chk("done_caddr_hold", 32'(bus.caddr), 32'd63);

        // Denormal flush; +0 passes unchanged
        do_start();
        chk("restart_done_clr", 32'(done), 32'd0);
        for (int i = 0; i < 64; i++) begin
            d = 16'h3C00 + 16'(i);
            e = d;
            if (i == 5)  begin d = 16'h8001; e = 16'h8000; end
            if (i == 9)  begin d = 16'h03FF; e = 16'h0000; end
            if (i == 12) begin d = 16'h0000; e = 16'h0000; end
            if (i == 13) begin d = 16'h8000; e = 16'h8000; end
            send_word(d, e, 1'b0, 1'b0);
        end
        drain();
        chk("denorm_cnt", 32'(denorm_cnt), 32'd2);
        chk("denorm_done", 32'(done), 32'd1);

        // Inf/NaN abort after ten words
        do_start();
        chk("start_denorm_clr", 32'(denorm_cnt), 32'd0);
        send_normals(0, 10);
        send_word(16'h7C00, 16'h0000, 1'b1, 1'b0);
        drain();
        chk("inf_err", 32'(err), 32'd1);
        chk("inf_done", 32'(done), 32'd0);
        chk("inf_s_ready", 32'(bus.s_ready), 32'd0);
        chk("inf_busy", 32'(busy), 32'd0);
        chk("inf_caddr_hold", 32'(bus.caddr), 32'd9);
        bus.s_valid = 1'b1;
        bus.s_data  = 16'h3C00;
        tick(3);
        bus.s_valid = 1'b0;
        chk("err_hold", 32'(err), 32'd1);
        do_start();
        chk("restart_err_clr", 32'(err), 32'd0);
        send_normals(0, 64);
        drain();
        chk("reload_done", 32'(done), 32'd1);

        // Bubbles: one write per accept, contiguous addresses
        n_cload = 0;
        do_start();
        for (int i = 0; i < 64; i++) begin
            send_word(16'hC000 + 16'(i), 16'hC000 + 16'(i), 1'b0, 1'b0);
            tick(2);
        end
        drain();
        chk("bubble_cload_count", 32'(n_cload), 32'd64);
        chk("bubble_done", 32'(done), 32'd1);

        // Reset mid-load
        do_start();
        send_normals(0, 20);
        @(negedge clk);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("midrst_s_ready", 32'(bus.s_ready), 32'd0);
        chk("midrst_cload", 32'(bus.cload), 32'd0);
        chk("midrst_caddr", 32'(bus.caddr), 32'd0);
        chk("midrst_cin", 32'(bus.cin), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        bus.s_valid = 1'b1;
        tick(3);
        bus.s_valid = 1'b0;
        chk("midrst_idle_s_ready", 32'(bus.s_ready), 32'd0);
        chk("midrst_sb_empty", 32'(sb.size()), 32'd0);

        // Start during LOAD ignored; start at DONE begins a new sequence
        do_start();
        send_normals(0, 30);
        send_word(16'h3C00 + 16'd30, 16'h3C00 + 16'd30, 1'b0, 1'b1);
        send_normals(31, 64);
        drain();
        chk("ign_start_done", 32'(done), 32'd1);
        do_start();
        chk("new_seq_done_clr", 32'(done), 32'd0);
        chk("new_seq_busy", 32'(busy), 32'd1);
        send_word(16'h5555, 16'h5555, 1'b0, 1'b0);
        drain();
        chk("new_seq_caddr0", 32'(bus.caddr), 32'd0);

        // rst wins over simultaneous start
        rst   = 1'b1;
        start = 1'b1;
        tick(1);
        rst   = 1'b0;
        start = 1'b0;
        chk("rst_start_s_ready", 32'(bus.s_ready), 32'd0);
        chk("rst_start_busy", 32'(busy), 32'd0);
        tick(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
